// File: rtl/prbs7_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prbs7_checker: self-synchronising 24-bit parallel PRBS7 receive checker    |
// | Option: PRBS7_CHK_BITCNT_EN makes err_cnt count bit errors, not words.     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module prbs7_checker #(
   parameter int WIDTH      = 24,
   parameter int TAP1       = 6,
   parameter int TAP2       = 5,
   parameter int LOCK_CNT   = 4,
   parameter int UNLOCK_CNT = 4,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic             clr_cnt,
   output logic             locked,
   output logic             err_word,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] word_cnt
);

   localparam int AMT_W = $clog2(WIDTH + 1);
   localparam int SUM_W = ((CNT_W > AMT_W) ? CNT_W : AMT_W) + 1;
   localparam logic [3:0]       LOCK_TGT   = 4'(LOCK_CNT);
   localparam logic [3:0]       UNLOCK_TGT = 4'(UNLOCK_CNT);
   localparam logic [SUM_W-1:0] CNT_MAX    = SUM_W'({CNT_W{1'b1}});

   typedef enum logic [0:0] {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] pred, pred_nxt;
   logic [3:0]       match_cnt, match_nxt;
   logic [3:0]       bad_cnt, bad_nxt;
   logic             seed, seed_nxt;
   logic             err_word_nxt;
   logic [CNT_W-1:0] err_cnt_nxt, word_cnt_nxt;
   logic             mismatch;
   logic [AMT_W-1:0] err_amt;
   logic [SUM_W-1:0] err_sum, word_sum;

   function automatic logic [WIDTH-1:0] next_word(input logic [WIDTH-1:0] w);
      logic [WIDTH-1:0] d;
      d = w;
      for (int i = 0; i < WIDTH; i++)
         d = {d[WIDTH-2:0], d[TAP1] ^ d[TAP2]};
      return d;
   endfunction

`ifdef PRBS7_CHK_BITCNT_EN
   function automatic logic [AMT_W-1:0] popcount(input logic [WIDTH-1:0] v);
      logic [AMT_W-1:0] n;
      n = '0;
      for (int i = 0; i < WIDTH; i++)
         n = n + AMT_W'(v[i]);
      return n;
   endfunction

   assign err_amt = popcount(din ^ pred);
`else
   assign err_amt = AMT_W'(1);
`endif

   assign mismatch = (din != pred);
   // One extra bit of headroom detects overflow so the counters can clamp.
   assign err_sum  = SUM_W'(err_cnt) + SUM_W'(err_amt);
   assign word_sum = SUM_W'(word_cnt) + SUM_W'(1);
   assign locked   = (state == LOCKED);

   always_comb begin
      state_nxt    = state;
      pred_nxt     = pred;
      match_nxt    = match_cnt;
      bad_nxt      = bad_cnt;
      seed_nxt     = seed;
      err_word_nxt = 1'b0;
      err_cnt_nxt  = err_cnt;
      word_cnt_nxt = word_cnt;
      if (din_valid) begin
         case (state)
            HUNT: begin
               pred_nxt = next_word(din);
               if (seed) begin
                  seed_nxt  = 1'b0;
                  match_nxt = '0;
               end else if (!mismatch) begin
                  match_nxt = match_cnt + 4'd1;
                  if (match_nxt == LOCK_TGT) begin
                     state_nxt = LOCKED;
                     bad_nxt   = '0;
                  end
               end else begin
                  match_nxt = '0;
               end
            end
            LOCKED: begin
               // Free-running prediction keeps a bad word from corrupting the next one.
               pred_nxt     = next_word(pred);
               word_cnt_nxt = (word_sum > CNT_MAX) ? {CNT_W{1'b1}} : word_sum[CNT_W-1:0];
               if (mismatch) begin
                  err_word_nxt = 1'b1;
                  err_cnt_nxt  = (err_sum > CNT_MAX) ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
                  bad_nxt      = bad_cnt + 4'd1;
                  if (bad_nxt == UNLOCK_TGT) begin
                     state_nxt = HUNT;
                     match_nxt = '0;
                     seed_nxt  = 1'b1;
                  end
               end else begin
                  bad_nxt = '0;
               end
            end
            default: state_nxt = HUNT;
         endcase
      end
      if (clr_cnt) begin
         err_cnt_nxt  = '0;
         word_cnt_nxt = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= HUNT;
         pred      <= '0;
         match_cnt <= '0;
         bad_cnt   <= '0;
         seed      <= 1'b1;
         err_word  <= 1'b0;
         err_cnt   <= '0;
         word_cnt  <= '0;
      end else begin
         state     <= state_nxt;
         pred      <= pred_nxt;
         match_cnt <= match_nxt;
         bad_cnt   <= bad_nxt;
         seed      <= seed_nxt;
         err_word  <= err_word_nxt;
         err_cnt   <= err_cnt_nxt;
         word_cnt  <= word_cnt_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_prbs7_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_prbs7_checker: scoreboard bench for prbs7_checker (32- and 4-bit cnts) |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_prbs7_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] din = '0;
   logic        din_valid = 1'b0;
   logic        clr_cnt = 1'b0;
   logic        locked, err_word;
   logic [31:0] err_cnt, word_cnt;
   logic        locked4, err_word4;
   logic [3:0]  err_cnt4, word_cnt4;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   prbs7_checker #(.CNT_W(32)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
      .locked(locked), .err_word(err_word), .err_cnt(err_cnt), .word_cnt(word_cnt)
   );

   prbs7_checker #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
      .locked(locked4), .err_word(err_word4), .err_cnt(err_cnt4), .word_cnt(word_cnt4)
   );

   typedef struct {
      logic        locked;
      logic        err_word;
      logic [31:0] err_cnt;
      logic [31:0] word_cnt;
      logic [3:0]  err_cnt4;
      logic [3:0]  word_cnt4;
   } exp_t;

   exp_t sb[$];

   // Reference model state
   logic        m_locked = 1'b0;
   logic [23:0] m_pred = '0;
   int          m_match = 0, m_bad = 0;
   logic        m_seed = 1'b1;
   logic        m_ew = 1'b0;
   longint      m_err = 0, m_word = 0, m_err4 = 0, m_word4 = 0;

   logic [23:0] gen = 24'h000001;

   function automatic logic [23:0] adv(input logic [23:0] w);
      logic [23:0] d;
      d = w;
      for (int i = 0; i < 24; i++) d = {d[22:0], d[6] ^ d[5]};
      return d;
   endfunction

   function automatic longint sat_add(input longint a, input longint b, input longint mx);
      return (a + b > mx) ? mx : a + b;
   endfunction

   function automatic logic [23:0] next_gen();
      logic [23:0] w;
      w = gen;
      gen = adv(gen);
      return w;
   endfunction

   task automatic model_step(input logic r, input logic v, input logic c, input logic [23:0] d);
      longint amt;
      m_ew = 1'b0;
      if (r) begin
         m_locked = 0; m_pred = '0; m_match = 0; m_bad = 0; m_seed = 1;
         m_err = 0; m_word = 0; m_err4 = 0; m_word4 = 0;
         return;
      end
      if (v) begin
         if (!m_locked) begin
            if (m_seed) m_seed = 0;
            else if (d == m_pred) begin
               m_match++;
               if (m_match == 4) begin m_locked = 1; m_bad = 0; end
            end else m_match = 0;
            m_pred = adv(d);
         end else begin
`ifdef PRBS7_CHK_BITCNT_EN
            amt = longint'($countones(d ^ m_pred));
`else
            amt = 1;
`endif
            m_word  = sat_add(m_word, 1, 64'hFFFF_FFFF);
            m_word4 = sat_add(m_word4, 1, 15);
            if (d != m_pred) begin
               m_ew = 1'b1;
               m_err  = sat_add(m_err, amt, 64'hFFFF_FFFF);
               m_err4 = sat_add(m_err4, amt, 15);
               m_bad++;
               if (m_bad == 4) begin m_locked = 0; m_match = 0; m_seed = 1; end
            end else m_bad = 0;
            m_pred = adv(m_pred);
         end
      end
      if (c) begin m_err = 0; m_word = 0; m_err4 = 0; m_word4 = 0; end
   endtask

   // Drive one cycle, push its expected outputs, and return after the monitor has checked.
   task automatic drive(input logic r, input logic v, input logic c, input logic [23:0] d);
      exp_t e;
      rst = r; din_valid = v; clr_cnt = c; din = d;
      model_step(r, v, c, d);
      e.locked = m_locked; e.err_word = m_ew;
      e.err_cnt = m_err[31:0]; e.word_cnt = m_word[31:0];
      e.err_cnt4 = m_err4[3:0]; e.word_cnt4 = m_word4[3:0];
      sb.push_back(e);
      @(posedge clk);
      #2;
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         n_vec += 6;
         if (locked !== e.locked) begin n_err++; $display("FAIL sb_locked got %b want %b", locked, e.locked); end
         if (err_word !== e.err_word) begin n_err++; $display("FAIL sb_err_word got %b want %b", err_word, e.err_word); end
         if (err_cnt !== e.err_cnt) begin n_err++; $display("FAIL sb_err_cnt got %0d want %0d", err_cnt, e.err_cnt); end
         if (word_cnt !== e.word_cnt) begin n_err++; $display("FAIL sb_word_cnt got %0d want %0d", word_cnt, e.word_cnt); end
         if (err_cnt4 !== e.err_cnt4) begin n_err++; $display("FAIL sb_err_cnt4 got %0d want %0d", err_cnt4, e.err_cnt4); end
         if (word_cnt4 !== e.word_cnt4) begin n_err++; $display("FAIL sb_word_cnt4 got %0d want %0d", word_cnt4, e.word_cnt4); end
      end
   end

   task automatic test_reset();
      drive(1, 0, 0, '0);
      drive(1, 1, 0, 24'h123456);
      n_vec++;
      if ({locked, err_word, err_cnt, word_cnt} !== '0) begin
         n_err++; $display("FAIL reset_outputs got %b/%b/%0d/%0d want 0/0/0/0", locked, err_word, err_cnt, word_cnt);
      end
   endtask

   task automatic test_clean_lock();
      gen = 24'h000001;
      for (int k = 1; k <= 8; k++) begin
         drive(0, 1, 0, next_gen());
         n_vec += 3;
         if (locked !== (k >= 5)) begin n_err++; $display("FAIL lock_time word %0d got %b want %b", k, locked, k >= 5); end
         if (word_cnt !== ((k >= 6) ? 32'(k - 5) : 32'd0)) begin
            n_err++; $display("FAIL lock_word_cnt word %0d got %0d want %0d", k, word_cnt, (k >= 6) ? k - 5 : 0);
         end
         if (err_cnt !== 32'd0) begin n_err++; $display("FAIL lock_err_cnt got %0d want 0", err_cnt); end
      end
   endtask

   task automatic test_single_bit();
      logic [31:0] base;
      base = err_cnt;
      drive(0, 1, 0, next_gen() ^ 24'h000001);
      n_vec += 2;
      if (err_word !== 1'b1) begin n_err++; $display("FAIL single_pulse got %b want 1", err_word); end
      if (err_cnt !== base + 32'd1) begin n_err++; $display("FAIL single_cnt got %0d want %0d", err_cnt, base + 1); end
      drive(0, 1, 0, next_gen());
      n_vec += 2;
      if (err_word !== 1'b0) begin n_err++; $display("FAIL single_no_prop got %b want 0", err_word); end
      if (locked !== 1'b1) begin n_err++; $display("FAIL single_locked got %b want 1", locked); end
   endtask

   task automatic test_multi_bit();
      logic [31:0] base, want;
      base = err_cnt;
`ifdef PRBS7_CHK_BITCNT_EN
      want = base + 32'd3;
`else
      want = base + 32'd1;
`endif
      drive(0, 1, 0, next_gen() ^ 24'h820001);
      n_vec++;
      if (err_cnt !== want) begin n_err++; $display("FAIL multi_cnt got %0d want %0d", err_cnt, want); end
      drive(0, 1, 0, next_gen());
   endtask

   task automatic test_loss_of_lock();
      logic [31:0] base, want;
      logic [23:0] w;
      base = err_cnt;
      want = base;
      for (int k = 1; k <= 4; k++) begin
         w = next_gen();
`ifdef PRBS7_CHK_BITCNT_EN
         want = want + 32'($countones(w));
`else
         want = want + 32'd1;
`endif
         drive(0, 1, 0, 24'h000000);
         n_vec++;
         if (locked !== (k < 4)) begin n_err++; $display("FAIL unlock_time zero %0d got %b want %b", k, locked, k < 4); end
      end
      n_vec++;
      if (err_cnt !== want) begin n_err++; $display("FAIL unlock_err_cnt got %0d want %0d", err_cnt, want); end
      for (int k = 1; k <= 5; k++) begin
         drive(0, 1, 0, next_gen());
         n_vec++;
         if (locked !== (k == 5)) begin n_err++; $display("FAIL relock word %0d got %b want %b", k, locked, k == 5); end
      end
   endtask

   task automatic test_gaps_clear();
      for (int k = 0; k < 6; k++) begin
         drive(0, 0, 0, 24'($urandom));
         n_vec++;
         if (err_word !== 1'b0) begin n_err++; $display("FAIL gap_idle got %b want 0", err_word); end
         drive(0, 1, 0, next_gen());
         n_vec++;
         if (err_word !== 1'b0) begin n_err++; $display("FAIL gap_pred_hold got %b want 0", err_word); end
      end
      drive(0, 1, 1, next_gen() ^ 24'h000100);
      n_vec += 2;
      if (err_cnt !== 32'd0 || word_cnt !== 32'd0) begin
         n_err++; $display("FAIL clr_priority got %0d/%0d want 0/0", err_cnt, word_cnt);
      end
      if (locked !== 1'b1) begin n_err++; $display("FAIL clr_keeps_lock got %b want 1", locked); end
   endtask

   task automatic test_saturation();
      drive(0, 1, 1, next_gen());
      for (int k = 0; k < 20; k++) begin
         drive(0, 1, 0, next_gen() ^ 24'h004000);
         drive(0, 1, 0, next_gen());
      end
      n_vec += 3;
      if (err_cnt4 !== 4'hF) begin n_err++; $display("FAIL sat_err_cnt4 got %h want f", err_cnt4); end
      if (err_cnt !== 32'd20) begin n_err++; $display("FAIL sat_err_cnt32 got %0d want 20", err_cnt); end
      if (word_cnt4 !== 4'hF) begin n_err++; $display("FAIL sat_word_cnt4 got %h want f", word_cnt4); end
   endtask

   task automatic test_reset_mid();
      drive(1, 1, 0, next_gen());
      n_vec++;
      if ({locked, err_word, err_cnt, word_cnt, locked4, err_cnt4, word_cnt4} !== '0) begin
         n_err++; $display("FAIL midreset_outputs got %b/%b/%0d/%0d want 0/0/0/0", locked, err_word, err_cnt, word_cnt);
      end
      for (int k = 1; k <= 5; k++) begin
         drive(0, 1, 0, next_gen());
         n_vec++;
         if (locked !== (k == 5)) begin n_err++; $display("FAIL midreset_hunt word %0d got %b want %b", k, locked, k == 5); end
      end
   endtask

   initial begin
      test_reset();
      test_clean_lock();
      test_single_bit();
      test_multi_bit();
      test_loss_of_lock();
      test_gaps_clear();
      test_saturation();
      test_reset_mid();
      drive(0, 0, 0, '0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
